// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM states.
package mdu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    typedef enum logic {
        StIdle,
        StBusy
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MIPS mult/multu/div/divu datapath producing the {HI, LO} pair.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
    assign a_neg   = (op == MD_DIV) & a[31];
    assign b_neg   = (op == MD_DIV) & b[31];
    assign mag_a   = a_neg ? (~a + 32'd1) : a;
    assign mag_b   = b_neg ? (~b + 32'd1) : b;
    assign quo     = mag_a / mag_b;
    assign rem     = mag_a % mag_b;
    assign quo_fix = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
    assign rem_fix = a_neg ? (~rem + 32'd1) : rem;

    always_comb begin
        hi = '0;
        lo = '0;
        unique case (op)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = rem_fix;
                    lo = quo_fix;
                end
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MD unit controller: owns HI/LO, sequences multi-cycle ops and raises the D-stage stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_pend_q;
    logic [31:0]      lo_pend_q;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;

    mdu_calc u_calc (
        .a  (src_a),
        .b  (src_b),
        .op (md_op),
        .hi (calc_hi),
        .lo (calc_lo)
    );

    // Result is computed at issue and parked until the busy window expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        hi_pend_q <= calc_hi;
                        lo_pend_q <= calc_lo;
                        cnt_q     <= md_op[1] ? DIV_CNT : MUL_CNT;
                        busy_q    <= 1'b1;
                        state_q   <= StBusy;
                    end else begin
                        if (wr_hi) hi_q <= wr_data;
                        if (wr_lo) lo_q <= wr_data;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        hi_q    <= hi_pend_q;
                        lo_q    <= lo_pend_q;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign stall   = d_is_md & (start | busy_q);
    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule
